// File: rtl/imem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// One transaction in flight; load/store has priority with a fetch starvation guard.
module imem_port_arbiter #(
  parameter int XLEN   = 32,
  parameter int LS_MAX = 4,
  parameter int CNT_W  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            redirect,
  output logic            stall_f,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  input  logic [3:0]      ls_be,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_LS} state_t;

  state_t           state, stateNext;
  logic             drop, dropNext;
  logic [CNT_W-1:0] streak, streakNext;
  logic             lsWeQ;
  logic [XLEN-1:0]  ifDataQ, lsDataQ;
  logic             selLs, selIf, streakFull;

  assign streakFull = (streak == CNT_W'(LS_MAX));

  always_comb begin
    stateNext = state;
    dropNext  = drop;
    selLs     = 1'b0;
    selIf     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'h0;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    case (state)
      IDLE: begin
        // A fetch is never issued while redirect is high: its address is stale.
        selLs = ls_req && !(if_req && streakFull);
        selIf = !selLs && if_req && !redirect;
        if (selLs) begin
          mem_req   = 1'b1;
          mem_we    = ls_we;
          mem_addr  = ls_addr;
          mem_wdata = ls_wdata;
          mem_be    = ls_be;
        end else if (selIf) begin
          mem_req  = 1'b1;
          mem_addr = if_addr;
          mem_be   = 4'hF;
        end
        if (mem_ready) begin
          ls_gnt = selLs;
          if_gnt = selIf;
          if (selLs)      stateNext = WAIT_LS;
          else if (selIf) stateNext = WAIT_IF;
        end
      end
      WAIT_IF: begin
        if (mem_rvalid) begin
          if_rvalid = !drop;
          stateNext = IDLE;
          dropNext  = 1'b0;
        end else if (redirect) begin
          dropNext = 1'b1;
        end
      end
      WAIT_LS: begin
        if (mem_rvalid) begin
          ls_rvalid = 1'b1;
          stateNext = IDLE;
          dropNext  = 1'b0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    streakNext = streak;
    if (!if_req || if_gnt)
      streakNext = '0;
    else if (ls_gnt && !streakFull)
      streakNext = streak + CNT_W'(1);
  end

  assign if_rdata = if_rvalid ? mem_rdata : ifDataQ;
  assign ls_rdata = ls_rvalid ? (lsWeQ ? '0 : mem_rdata) : lsDataQ;
  assign stall_f  = if_req && !if_rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      drop    <= 1'b0;
      streak  <= '0;
      lsWeQ   <= 1'b0;
      ifDataQ <= '0;
      lsDataQ <= '0;
    end else begin
      state  <= stateNext;
      drop   <= dropNext;
      streak <= streakNext;
      if (ls_gnt)    lsWeQ   <= ls_we;
      if (if_rvalid) ifDataQ <= if_rdata;
      if (ls_rvalid) lsDataQ <= ls_rdata;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: behavioural memory with programmable
// latency/backpressure, scoreboard queues for fetch and load/store responses.
module tb_imem_port_arbiter;
  localparam int XLEN   = 32;
  localparam int LS_MAX = 4;
  localparam int CNT_W  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            if_req = 1'b0;
  logic [XLEN-1:0] if_addr = '0;
  logic            if_gnt, if_rvalid;
  logic [XLEN-1:0] if_rdata;
  logic            redirect = 1'b0;
  logic            stall_f;
  logic            ls_req = 1'b0;
  logic            ls_we = 1'b0;
  logic [XLEN-1:0] ls_addr = '0;
  logic [XLEN-1:0] ls_wdata = '0;
  logic [3:0]      ls_be = 4'hF;
  logic            ls_gnt, ls_rvalid;
  logic [XLEN-1:0] ls_rdata;
  logic            mem_req, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_ready = 1'b0;
  logic            mem_rvalid = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.XLEN(XLEN), .LS_MAX(LS_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .redirect(redirect), .stall_f(stall_f),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] ifExp[$];
  logic [31:0] lsExp[$];
  logic [31:0] memArr[logic [31:0]];
  int memLat = 1;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return {a[15:0], 16'hC0DE};
  endfunction

  // Memory model: acceptance seen mid-cycle, response memLat cycles after the grant cycle.
  logic        accSeen = 1'b0;
  logic        accWe;
  logic [31:0] accAddr, accWdata;
  logic [3:0]  accBe;
  logic        memBusy = 1'b0;
  int          memRem = 0;
  logic [31:0] memResp;

  always @(negedge clk) begin
    if (!rst && mem_req && mem_ready) begin
      accSeen  = 1'b1;
      accWe    = mem_we;
      accAddr  = mem_addr;
      accWdata = mem_wdata;
      accBe    = mem_be;
    end
  end

  always @(posedge clk) begin
    logic [31:0] cur;
    #1;
    mem_rvalid = 1'b0;
    if (accSeen) begin
      accSeen = 1'b0;
      memBusy = 1'b1;
      memRem  = memLat;
      if (accWe) begin
        cur = memRead(accAddr);
        for (int b = 0; b < 4; b++)
          if (accBe[b]) cur[b*8 +: 8] = accWdata[b*8 +: 8];
        memArr[accAddr] = cur;
        memResp = 32'hFFFF_FFFF;
      end else begin
        memResp = memRead(accAddr);
      end
    end
    if (memBusy) begin
      memRem--;
      if (memRem == 0) begin
        memBusy    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = memResp;
      end
    end
  end

  // Scoreboard: every delivered response must match the next expected value.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_rvalid) begin
        if (ifExp.size() == 0) checkVal("if_unexpected_rvalid", 32'd1, 32'd0);
        else                   checkVal("if_rdata", if_rdata, ifExp.pop_front());
      end
      if (ls_rvalid) begin
        if (lsExp.size() == 0) checkVal("ls_unexpected_rvalid", 32'd1, 32'd0);
        else                   checkVal("ls_rdata", ls_rdata, lsExp.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitRvalid(input bit isIf, input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = isIf ? if_rvalid : ls_rvalid;
    end
    checkVal(tag, {31'd0, seen}, 32'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit grantLog[$];
    bit expOrder[$];
    int st;

    memArr[32'h0] = 32'h0050_0093;
    memArr[32'h8] = 32'hDEAD_BEEF;

    // reset state
    repeat (3) @(negedge clk);
    checkVal("rst_mem_req", mem_req, 0);
    checkVal("rst_if_gnt", if_gnt, 0);
    checkVal("rst_ls_gnt", ls_gnt, 0);
    checkVal("rst_stall_f", stall_f, 0);
    checkVal("rst_mem_addr", mem_addr, 0);
    checkVal("rst_mem_be", mem_be, 0);
    checkVal("rst_if_rdata", if_rdata, 0);
    checkVal("rst_ls_rdata", ls_rdata, 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: single fetch, latency 2
    memLat = 2; mem_ready = 1'b1;
    if_req = 1'b1; if_addr = 32'h0;
    ifExp.push_back(32'h0050_0093);
    @(negedge clk);
    checkVal("t1_if_gnt", if_gnt, 1);
    checkVal("t1_mem_addr", mem_addr, 0);
    checkVal("t1_mem_be", mem_be, 4'hF);
    checkVal("t1_mem_we", mem_we, 0);
    checkVal("t1_stall_c1", stall_f, 1);
    tick();
    @(negedge clk);
    checkVal("t1_stall_c2", stall_f, 1);
    checkVal("t1_mem_req_wait", mem_req, 0);
    checkVal("t1_rvalid_c2", if_rvalid, 0);
    tick();
    @(negedge clk);
    checkVal("t1_rvalid_c3", if_rvalid, 1);
    checkVal("t1_stall_c3", stall_f, 0);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    checkVal("t1_rdata_hold", if_rdata, 32'h0050_0093);
    tick();

    // 2: simultaneous requests, LS first
    memLat = 1;
    if_req = 1'b1; if_addr = 32'h20;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100; ls_be = 4'hF;
    lsExp.push_back(memRead(32'h100));
    ifExp.push_back(memRead(32'h20));
    @(negedge clk);
    checkVal("t2_ls_gnt", ls_gnt, 1);
    checkVal("t2_if_gnt_a", if_gnt, 0);
    checkVal("t2_mem_addr_ls", mem_addr, 32'h100);
    checkVal("t2_stall_a", stall_f, 1);
    tick();
    ls_req = 1'b0;
    @(negedge clk);
    checkVal("t2_ls_rvalid", ls_rvalid, 1);
    checkVal("t2_if_gnt_b", if_gnt, 0);
    checkVal("t2_stall_b", stall_f, 1);
    tick();
    @(negedge clk);
    checkVal("t2_if_gnt_c", if_gnt, 1);
    checkVal("t2_mem_addr_if", mem_addr, 32'h20);
    checkVal("t2_stall_c", stall_f, 1);
    tick();
    @(negedge clk);
    checkVal("t2_if_rvalid", if_rvalid, 1);
    tick();
    if_req = 1'b0;
    tick();

    // 3: starvation guard under continuous contention
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h104;
    if_req = 1'b1; if_addr = 32'h24;
    st = 0;
    for (int i = 0; i < 10; i++) begin
      if (st == LS_MAX) begin
        expOrder.push_back(1'b1); st = 0;
        ifExp.push_back(memRead(32'h24));
      end else begin
        expOrder.push_back(1'b0); st++;
        lsExp.push_back(memRead(32'h104));
      end
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (if_gnt) grantLog.push_back(1'b1);
      if (ls_gnt) grantLog.push_back(1'b0);
      if (grantLog.size() >= 10) break;
      tick();
    end
    tick();
    ls_req = 1'b0; if_req = 1'b0;
    repeat (3) tick();
    checkVal("t3_num_grants", grantLog.size(), 10);
    for (int i = 0; i < 10 && i < grantLog.size(); i++)
      checkVal($sformatf("t3_grant%0d", i), {31'd0, grantLog[i]}, {31'd0, expOrder[i]});

    // 4: redirect while fetch outstanding
    memLat = 3;
    if_req = 1'b1; if_addr = 32'h8;
    @(negedge clk);
    checkVal("t4_if_gnt", if_gnt, 1);
    tick();
    redirect = 1'b1; if_addr = 32'h40;
    ifExp.push_back(memRead(32'h40));
    @(negedge clk);
    checkVal("t4_stall_redirect", stall_f, 1);
    tick();
    redirect = 1'b0;
    tick();
    @(negedge clk);
    checkVal("t4_dropped_rvalid", if_rvalid, 0);
    checkVal("t4_stall_drop", stall_f, 1);
    tick();
    @(negedge clk);
    checkVal("t4_reissue_gnt", if_gnt, 1);
    checkVal("t4_reissue_addr", mem_addr, 32'h40);
    tick();
    waitRvalid(1'b1, "t4_if_rvalid");
    if_req = 1'b0;
    tick();

    // 5: write with backpressure, then read back the merged word
    memLat = 1; mem_ready = 1'b0;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h1122_3344; ls_be = 4'b0011;
    lsExp.push_back(32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkVal($sformatf("t5_mem_req_c%0d", c), mem_req, 1);
      checkVal($sformatf("t5_mem_addr_c%0d", c), mem_addr, 32'h200);
      checkVal($sformatf("t5_mem_be_c%0d", c), mem_be, 4'b0011);
      checkVal($sformatf("t5_no_gnt_c%0d", c), ls_gnt, 0);
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checkVal("t5_ls_gnt", ls_gnt, 1);
    checkVal("t5_mem_we", mem_we, 1);
    checkVal("t5_mem_wdata", mem_wdata, 32'h1122_3344);
    tick();
    ls_req = 1'b0; ls_we = 1'b0;
    waitRvalid(1'b0, "t5_ls_ack");
    ls_req = 1'b1; ls_be = 4'hF;
    lsExp.push_back(32'h0200_3344);
    @(negedge clk);
    checkVal("t5_rd_gnt", ls_gnt, 1);
    tick();
    ls_req = 1'b0;
    waitRvalid(1'b0, "t5_rd_rvalid");

    // 6: reset during WAIT_LS, late response ignored
    memLat = 3;
    ls_req = 1'b1; ls_addr = 32'h300;
    @(negedge clk);
    checkVal("t6_ls_gnt", ls_gnt, 1);
    tick();
    ls_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkVal("t6_rst_mem_req", mem_req, 0);
    checkVal("t6_rst_ls_rvalid", ls_rvalid, 0);
    checkVal("t6_rst_if_rdata", if_rdata, 0);
    checkVal("t6_rst_ls_rdata", ls_rdata, 0);
    checkVal("t6_rst_stall", stall_f, 0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    checkVal("t6_late_ls_rvalid", ls_rvalid, 0);
    checkVal("t6_late_if_rvalid", if_rvalid, 0);
    checkVal("t6_late_mem_req", mem_req, 0);
    tick();
    if_req = 1'b1; if_addr = 32'h44;
    ifExp.push_back(memRead(32'h44));
    @(negedge clk);
    checkVal("t6_if_gnt", if_gnt, 1);
    tick();
    waitRvalid(1'b1, "t6_if_rvalid");
    if_req = 1'b0;
    repeat (2) tick();

    checkVal("if_queue_empty", ifExp.size(), 0);
    checkVal("ls_queue_empty", lsExp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
